// File: rtl/case_1_mul_arb_pkg.sv
// Shared types and default widths for the arbitrated multiplier.
package case_1_mul_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } state_t;

  localparam int DEF_N_REQ     = 4;
  localparam int DEF_DIN0_W    = 14;
  localparam int DEF_DIN1_W    = 12;
  localparam int DEF_DOUT_W    = DEF_DIN0_W + DEF_DIN1_W;
  localparam int DEF_NUM_STAGE = 2;

endpackage

// File: rtl/case_1_mul_pipe.sv
// NUM_STAGE-deep signed multiplier carrying a valid bit and requester id,
// all stages advancing together on a common enable.
module case_1_mul_pipe
  import case_1_mul_arb_pkg::*;
#(
  parameter int DIN0_W    = DEF_DIN0_W,
  parameter int DIN1_W    = DEF_DIN1_W,
  parameter int DOUT_W    = DEF_DOUT_W,
  parameter int NUM_STAGE = DEF_NUM_STAGE,
  parameter int ID_W      = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     in_valid,
  input  logic [ID_W-1:0]          in_id,
  input  logic signed [DIN0_W-1:0] in_din0,
  input  logic signed [DIN1_W-1:0] in_din1,
  output logic                     out_valid,
  output logic [ID_W-1:0]          out_id,
  output logic signed [DOUT_W-1:0] out_dout,
  output logic                     inner_valid
);

  logic signed [DOUT_W-1:0] prod;
  logic [NUM_STAGE-1:0]     vld_q;
  logic [DOUT_W-1:0]        dout_q [NUM_STAGE];
  logic [ID_W-1:0]          id_q   [NUM_STAGE];

  // Size casts keep signedness, so both operands sign-extend to full width.
  assign prod = DOUT_W'(in_din0) * DOUT_W'(in_din1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      // NOTE: data stages are reset too, so rsp_dout/rsp_id read zero after reset.
      for (int i = 0; i < NUM_STAGE; i++) begin
        dout_q[i] <= '0;
        id_q[i]   <= '0;
      end
    end else if (en) begin
      // NOTE: non-blocking assignments let every stage sample its predecessor's old value.
      vld_q[0]  <= in_valid;
      dout_q[0] <= prod;
      id_q[0]   <= in_id;
      for (int i = 1; i < NUM_STAGE; i++) begin
        vld_q[i]  <= vld_q[i-1];
        dout_q[i] <= dout_q[i-1];
        id_q[i]   <= id_q[i-1];
      end
    end
  end

  // Valid ops that will still be inside the pipe after the next advance.
  always_comb begin
    inner_valid = 1'b0;
    for (int i = 0; i < NUM_STAGE - 1; i++) inner_valid = inner_valid | vld_q[i];
  end

  assign out_valid = vld_q[NUM_STAGE-1];
  assign out_dout  = dout_q[NUM_STAGE-1];
  assign out_id    = id_q[NUM_STAGE-1];

endmodule

// File: rtl/case_1_mul_arb.sv
// N_REQ requesters sharing one pipelined signed multiplier.
// Round-robin arbitration by default; CASE_1_MUL_ARB_PRIO_EN selects fixed priority.
module case_1_mul_arb
  import case_1_mul_arb_pkg::*;
#(
  parameter int N_REQ     = DEF_N_REQ,
  parameter int DIN0_W    = DEF_DIN0_W,
  parameter int DIN1_W    = DEF_DIN1_W,
  parameter int DOUT_W    = DEF_DOUT_W,
  parameter int NUM_STAGE = DEF_NUM_STAGE,
  localparam int ID_W     = $clog2(N_REQ)
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ*DIN0_W-1:0]   req_din0,
  input  logic [N_REQ*DIN1_W-1:0]   req_din1,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic signed [DOUT_W-1:0]  rsp_dout,
  output logic [ID_W-1:0]           rsp_id,
  output logic                      busy
);

  state_t           state_q, state_d;
  logic             run_q;
  logic             pipe_en, accept, gnt_any, inner_valid, next_any;
  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_idx;

  assign pipe_en = !(rsp_valid && !rsp_ready);

`ifdef CASE_1_MUL_ARB_PRIO_EN
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!gnt_any && req_valid[i]) begin
        gnt_any = 1'b1;
        gnt_idx = ID_W'(i);
        gnt[i]  = 1'b1;
      end
    end
  end
`else
  logic [ID_W-1:0] rr_ptr;

  // NOTE: every variable gets a default before the search so no latch is inferred.
  always_comb begin
    int idx;
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int off = 0; off < N_REQ; off++) begin
      idx = int'(rr_ptr) + off;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!gnt_any && req_valid[idx]) begin
        gnt_any  = 1'b1;
        gnt_idx  = ID_W'(idx);
        gnt[idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n)   rr_ptr <= '0;
    else if (accept) rr_ptr <= (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  end
`endif

  // run_q holds off acceptance until the first clock edge after reset release.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) run_q <= 1'b0;
    else           run_q <= 1'b1;
  end

  assign req_ready = (run_q && pipe_en) ? gnt : '0;
  assign accept    = run_q && pipe_en && gnt_any;

  case_1_mul_pipe #(
    .DIN0_W   (DIN0_W),
    .DIN1_W   (DIN1_W),
    .DOUT_W   (DOUT_W),
    .NUM_STAGE(NUM_STAGE),
    .ID_W     (ID_W)
  ) u_pipe (
    .clk        (ap_clk),
    .rst_n      (ap_rst_n),
    .en         (pipe_en),
    .in_valid   (accept),
    .in_id      (gnt_idx),
    .in_din0    (req_din0[int'(gnt_idx)*DIN0_W +: DIN0_W]),
    .in_din1    (req_din1[int'(gnt_idx)*DIN1_W +: DIN1_W]),
    .out_valid  (rsp_valid),
    .out_id     (rsp_id),
    .out_dout   (rsp_dout),
    .inner_valid(inner_valid)
  );

  // Whether any stage will hold a valid op after this edge.
  assign next_any = pipe_en ? (accept || inner_valid) : 1'b1;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Leaving STALL with nothing left in flight goes straight to IDLE so busy
  // never reports an empty pipeline.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN: begin
        if (!pipe_en)      state_d = STALL;
        else if (!next_any) state_d = IDLE;
      end
      STALL:   if (rsp_ready) state_d = next_any ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_case_1_mul_arb.sv
// Randomized bench for case_1_mul_arb against a queue-based reference model.
module tb_case_1_mul_arb;

  localparam int N_REQ     = 4;
  localparam int DIN0_W    = 14;
  localparam int DIN1_W    = 12;
  localparam int DOUT_W    = 26;
  localparam int NUM_STAGE = 2;
  localparam int ID_W      = $clog2(N_REQ);

  logic                     ap_clk = 1'b0;
  logic                     ap_rst_n;
  logic [N_REQ-1:0]         req_valid;
  logic [N_REQ-1:0]         req_ready;
  logic [N_REQ*DIN0_W-1:0]  req_din0;
  logic [N_REQ*DIN1_W-1:0]  req_din1;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic signed [DOUT_W-1:0] rsp_dout;
  logic [ID_W-1:0]          rsp_id;
  logic                     busy;

  always #5 ap_clk = ~ap_clk;

  case_1_mul_arb #(
    .N_REQ(N_REQ), .DIN0_W(DIN0_W), .DIN1_W(DIN1_W), .DOUT_W(DOUT_W), .NUM_STAGE(NUM_STAGE)
  ) dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_din0 (req_din0),
    .req_din1 (req_din1),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_dout (rsp_dout),
    .rsp_id   (rsp_id),
    .busy     (busy)
  );

  // Model: each accepted op carries its exact product and the number of
  // unstalled cycles it has spent in flight; it is presented at age NUM_STAGE.
  typedef struct {
    longint prod;
    int     id;
    int     age;
  } op_t;

  op_t    inflight[$];
  int     rr = 0;
  int     total = 0;
  int     bad = 0;
  logic   last_rv;
  longint last_dout;

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_grant(input logic [N_REQ-1:0] v);
    int g = -1;
    for (int k = 0; k < N_REQ; k++) begin
`ifdef CASE_1_MUL_ARB_PRIO_EN
      int idx = k;
`else
      int idx = (rr + k) % N_REQ;
`endif
      if (g < 0 && v[idx]) g = idx;
    end
    return g;
  endfunction

  // One clock: drive, compare against the model, then advance the model.
  task automatic step(input logic [N_REQ-1:0] v, input logic [N_REQ*DIN0_W-1:0] a,
                      input logic [N_REQ*DIN1_W-1:0] b, input logic rdy);
    int               g;
    logic             exp_rv, pe;
    logic [N_REQ-1:0] exp_rdy;
    @(negedge ap_clk);
    req_valid = v;
    req_din0  = a;
    req_din1  = b;
    rsp_ready = rdy;
    #1;
    exp_rv  = (inflight.size() > 0) && (inflight[0].age == NUM_STAGE);
    pe      = !(exp_rv && !rdy);
    g       = model_grant(v);
    exp_rdy = '0;
    if (g >= 0 && pe) exp_rdy[g] = 1'b1;
    check("req_ready", req_ready, exp_rdy);
    check("rsp_valid", rsp_valid, exp_rv);
    check("busy", busy, inflight.size() > 0);
    if (exp_rv) begin
      check("rsp_dout", rsp_dout, inflight[0].prod);
      check("rsp_id", rsp_id, inflight[0].id);
    end
    last_rv   = rsp_valid;
    last_dout = rsp_dout;
    @(posedge ap_clk);
    if (pe) begin
      if (exp_rv) void'(inflight.pop_front());
      foreach (inflight[i]) inflight[i].age++;
      if (g >= 0) begin
        op_t o;
        o.prod = longint'($signed(a[g*DIN0_W +: DIN0_W])) * longint'($signed(b[g*DIN1_W +: DIN1_W]));
        o.id   = g;
        o.age  = 1;
        inflight.push_back(o);
        rr = (g + 1) % N_REQ;
      end
    end
  endtask

  function automatic logic [N_REQ*DIN0_W-1:0] put0(input logic [N_REQ*DIN0_W-1:0] a, input int i, input int val);
    a[i*DIN0_W +: DIN0_W] = DIN0_W'(val);
    return a;
  endfunction

  function automatic logic [N_REQ*DIN1_W-1:0] put1(input logic [N_REQ*DIN1_W-1:0] b, input int i, input int val);
    b[i*DIN1_W +: DIN1_W] = DIN1_W'(val);
    return b;
  endfunction

  task automatic rand_ops(output logic [N_REQ*DIN0_W-1:0] a, output logic [N_REQ*DIN1_W-1:0] b);
    for (int i = 0; i < N_REQ; i++) begin
      case ($urandom_range(7))
        0:       begin a[i*DIN0_W +: DIN0_W] = {1'b1, {(DIN0_W-1){1'b0}}};
                       b[i*DIN1_W +: DIN1_W] = {1'b1, {(DIN1_W-1){1'b0}}}; end
        1:       begin a[i*DIN0_W +: DIN0_W] = {1'b0, {(DIN0_W-1){1'b1}}};
                       b[i*DIN1_W +: DIN1_W] = {1'b1, {(DIN1_W-1){1'b0}}}; end
        default: begin a[i*DIN0_W +: DIN0_W] = DIN0_W'($urandom());
                       b[i*DIN1_W +: DIN1_W] = DIN1_W'($urandom()); end
      endcase
    end
  endtask

  task automatic reset_now();
    @(negedge ap_clk);
    #2;
    ap_rst_n = 1'b0;
    #1;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_rsp_dout", rsp_dout, 0);
    check("rst_rsp_id", rsp_id, 0);
    inflight.delete();
    rr = 0;
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
  endtask

  logic [N_REQ*DIN0_W-1:0] a;
  logic [N_REQ*DIN1_W-1:0] b;

  initial begin
    ap_rst_n  = 1'b0;
    req_valid = '0;
    req_din0  = '0;
    req_din1  = '0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge ap_clk);
    check("init_rsp_valid", rsp_valid, 0);
    check("init_req_ready", req_ready, 0);
    check("init_busy", busy, 0);
    ap_rst_n = 1'b1;

    // Single request: -3 * 5 appears two cycles after acceptance.
    step(4'b0001, put0('0, 0, -3), put1('0, 0, 5), 1'b1);
    step('0, '0, '0, 1'b1);
    step('0, '0, '0, 1'b1);
    check("single_latency", last_rv, 1);
    check("single_dout", last_dout, -15);
    step('0, '0, '0, 1'b1);

    // Extreme operands on requester 2, then requester 3.
    step(4'b0100, put0('0, 2, -8192), put1('0, 2, -2048), 1'b1);
    step(4'b1000, put0('0, 3, 8191), put1('0, 3, -2048), 1'b1);
    step('0, '0, '0, 1'b1);
    check("extreme_neg_neg", last_dout, 16777216);
    step('0, '0, '0, 1'b1);
    check("extreme_pos_neg", last_dout, -16775168);

    // All requesters streaming, then a 3-cycle downstream stall, then release.
    rand_ops(a, b);
    repeat (8) step('1, a, b, 1'b1);
    repeat (3) step('1, a, b, 1'b0);
    repeat (6) step('1, a, b, 1'b1);
    repeat (4) step('0, '0, '0, 1'b1);

    // Requesters 1 and 3 both pending continuously.
    repeat (8) begin rand_ops(a, b); step(4'b1010, a, b, 1'b1); end

    // Reset with two ops in flight; arbitration restarts from requester 0.
    step(4'b0011, a, b, 1'b1);
    step(4'b0011, a, b, 1'b1);
    reset_now();
    repeat (6) step('1, a, b, 1'b1);

    // Randomized traffic with random backpressure and occasional resets.
    for (int n = 0; n < 3000; n++) begin
      rand_ops(a, b);
      if ($urandom_range(999) == 0) reset_now();
      else step(N_REQ'($urandom()), a, b, ($urandom_range(9) < 7));
    end
    repeat (6) step('0, '0, '0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
